// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: FSM encoding, BCD width, field select.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int BCD_W = 4;

    // FSM state encoding, kept as plain constants for legacy tools
    localparam logic [1:0] PAUSE  = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] ADJUST = 2'd2;

    // Adjust field select
    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

    // Split a decimal value 0..99 into its BCD tens and ones digits
    function automatic logic [BCD_W-1:0] bcd_tens(input int unsigned v);
        return BCD_W'(v / 10);
    endfunction

    function automatic logic [BCD_W-1:0] bcd_ones(input int unsigned v);
        return BCD_W'(v % 10);
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Bundle of the stopwatch controller's divider/button inputs and display outputs.
// Latency: n/a (wires only).
// Backpressure: none; all inputs are levels or one-cycle pulses, outputs are always valid.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic             clock1hz;
    logic             clock2hz;
    logic             clock_adjust;
    logic             btn_pause;
    logic             btn_clear;
    logic             sw_adj;
    logic             sw_sel;
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic             running;
    logic             blank_min;
    logic             blank_sec;
    logic             rollover;

    // Environment side: divider, buttons and switches, display driver
    modport master (
        output clock1hz, clock2hz, clock_adjust, btn_pause, btn_clear, sw_adj, sw_sel,
        input  min_tens, min_ones, sec_tens, sec_ones, running, blank_min, blank_sec, rollover
    );

    // Controller side
    modport slave (
        input  clock1hz, clock2hz, clock_adjust, btn_pause, btn_clear, sw_adj, sw_sel,
        output min_tens, min_ones, sec_tens, sec_ones, running, blank_min, blank_sec, rollover
    );

endinterface

// File: rtl/stopwatch_bcd2_counter.sv
// Two-digit BCD counter 00..LIMIT that wraps to 00, with synchronous clear.
// Latency: digits update one cycle after i_inc/i_clr; o_carry is combinational with i_inc.
// Backpressure: none; i_clr wins over i_inc.
module bcd2_counter
    import stopwatch_pkg::*;
#(
    parameter int LIMIT = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones,
    output logic             o_carry
);

    localparam logic [BCD_W-1:0] LIM_T = bcd_tens(LIMIT);
    localparam logic [BCD_W-1:0] LIM_O = bcd_ones(LIMIT);

    logic [BCD_W-1:0] r_tens;
    logic [BCD_W-1:0] r_ones;
    logic             w_at_limit;

    assign w_at_limit = (r_tens == LIM_T) && (r_ones == LIM_O);
    assign o_carry    = i_inc && w_at_limit;
    assign o_tens     = r_tens;
    assign o_ones     = r_ones;

    // Count up in BCD, wrapping to 00 after LIMIT; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_clr) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_inc) begin
            if (w_at_limit) begin
                r_tens <= '0;
                r_ones <= '0;
            end else if (r_ones == BCD_W'(9)) begin
                r_ones <= '0;
                r_tens <= r_tens + BCD_W'(1);
            end else begin
                r_ones <= r_ones + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM (pause/run/adjust), divider edge detection, MM:SS BCD time and adjust blink.
// Latency: every output is registered; an input or strobe in cycle N shows in cycle N+1.
// Backpressure: none; strobes and button pulses are consumed in the cycle they occur.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MINUTE_LIMIT = 59
) (
    input  logic        master_clock,
    input  logic        rst,
    stopwatch_if.slave  bus
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_clk1_q;
    logic       r_clk2_q;
    logic       r_clkadj_q;
    logic       r_sel_q;
    logic       r_running;
    logic       r_blank_min;
    logic       r_blank_sec;
    logic       r_rollover;

    logic       w_tick1;
    logic       w_tick2;
    logic       w_tick_adj;
    logic       w_run_tick;
    logic       w_adj_sec;
    logic       w_adj_min;
    logic       w_sec_inc;
    logic       w_min_inc;
    logic       w_sec_carry;
    logic       w_min_carry;
    logic       w_in_adj_nxt;
    logic       w_blink_reset;

    // Rising-edge strobes from the divider levels
    assign w_tick1    = bus.clock1hz     & ~r_clk1_q;
    assign w_tick2    = bus.clock2hz     & ~r_clk2_q;
    assign w_tick_adj = bus.clock_adjust & ~r_clkadj_q;

    // Delay registers for the edge detectors and the field-select change detector
    always_ff @(posedge master_clock or negedge rst) begin
        if (!rst) begin
            r_clk1_q   <= 1'b0;
            r_clk2_q   <= 1'b0;
            r_clkadj_q <= 1'b0;
            r_sel_q    <= 1'b0;
        end else begin
            r_clk1_q   <= bus.clock1hz;
            r_clk2_q   <= bus.clock2hz;
            r_clkadj_q <= bus.clock_adjust;
            r_sel_q    <= bus.sw_sel;
        end
    end

    // Next state from the current state; the adjust switch overrides the pause button
    always_comb begin
        w_state_nxt = r_state;
        if (bus.sw_adj) begin
            w_state_nxt = ADJUST;
        end else begin
            case (r_state)
                PAUSE:   if (bus.btn_pause) w_state_nxt = RUN;
                RUN:     if (bus.btn_pause) w_state_nxt = PAUSE;
                default: w_state_nxt = PAUSE;
            endcase
        end
    end

    // State register and its registered RUN decode
    always_ff @(posedge master_clock or negedge rst) begin
        if (!rst) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN);
        end
    end

    // Counting: seconds carry into minutes only while running; adjust steps one field alone
    assign w_run_tick = (r_state == RUN) && w_tick1;
    assign w_adj_sec  = (r_state == ADJUST) && w_tick_adj && (bus.sw_sel == SEL_SEC);
    assign w_adj_min  = (r_state == ADJUST) && w_tick_adj && (bus.sw_sel == SEL_MIN);
    assign w_sec_inc  = w_run_tick | w_adj_sec;
    assign w_min_inc  = (w_run_tick & w_sec_carry) | w_adj_min;

    bcd2_counter #(.LIMIT(59)) u_sec (
        .clk     (master_clock),
        .rst_n   (rst),
        .i_inc   (w_sec_inc),
        .i_clr   (bus.btn_clear),
        .o_tens  (bus.sec_tens),
        .o_ones  (bus.sec_ones),
        .o_carry (w_sec_carry)
    );

    bcd2_counter #(.LIMIT(MINUTE_LIMIT)) u_min (
        .clk     (master_clock),
        .rst_n   (rst),
        .i_inc   (w_min_inc),
        .i_clr   (bus.btn_clear),
        .o_tens  (bus.min_tens),
        .o_ones  (bus.min_ones),
        .o_carry (w_min_carry)
    );

    // Full wrap pulse; a clear in the same cycle suppresses it since the time is zeroed anyway
    always_ff @(posedge master_clock or negedge rst) begin
        if (!rst) begin
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= w_run_tick & w_sec_carry & w_min_carry & ~bus.btn_clear;
        end
    end

    // Blink restarts unblanked on entry to ADJUST or when the selected field changes
    assign w_in_adj_nxt  = (w_state_nxt == ADJUST);
    assign w_blink_reset = (r_state != ADJUST) || (bus.sw_sel != r_sel_q);

    // Toggle the selected field's blank on each blink strobe; the other field stays visible
    always_ff @(posedge master_clock or negedge rst) begin
        if (!rst) begin
            r_blank_min <= 1'b0;
            r_blank_sec <= 1'b0;
        end else if (!w_in_adj_nxt || w_blink_reset) begin
            r_blank_min <= 1'b0;
            r_blank_sec <= 1'b0;
        end else if (w_tick2) begin
            if (bus.sw_sel == SEL_SEC) begin
                r_blank_sec <= ~r_blank_sec;
                r_blank_min <= 1'b0;
            end else begin
                r_blank_min <= ~r_blank_min;
                r_blank_sec <= 1'b0;
            end
        end
    end

    assign bus.running   = r_running;
    assign bus.blank_min = r_blank_min;
    assign bus.blank_sec = r_blank_sec;
    assign bus.rollover  = r_rollover;

endmodule
